cam_capture_ctrl: RTL and testbench
===================================

Name: cam_capture_ctrl

Overview:
- Frame-capture sequencer between the parallel sensor pins (FV, LV, D_IN on pclk) and the AXI-Stream packer.
- Arms and stops capture on command, syncs to a clean frame boundary, and applies frame decimation.
- Checks frame geometry against configured width and height, and emits aligned pixel strobes with start-of-frame (SOF) and end-of-line (EOL) markers that the packer maps to tuser/tlast.
- Flags FIFO overflow and geometry errors, and keeps frame and overflow statistics.

Parameters:
- DATA_W, 16, pixel width (D_IN / pix_data)
- CNT_W, 12, width of pixel/line counters and geometry config
- SKIP_W, 4, width of decimation config

Ports:
- pclk  in  1  sensor pixel clock; sole clock
- reset  in  1  synchronous, active-high reset
- FV  in  1  sensor frame valid
- LV  in  1  sensor line valid
- D_IN  in  DATA_W  sensor pixel data
- arm  in  1  pulse: start capture
- stop  in  1  pulse: stop capture
- cont_en  in  1  1 = continuous capture, 0 = single frame
- skip_cfg  in  SKIP_W  capture 1 frame of every skip_cfg+1
- width_cfg  in  CNT_W  expected pixels per line (>=1)
- height_cfg  in  CNT_W  expected lines per frame (>=1)
- fifo_full  in  1  downstream FIFO full
- pix_valid  out  1  pixel strobe to packer
- pix_data  out  DATA_W  pixel data
- pix_sof  out  1  first pixel of captured frame
- pix_eol  out  1  last pixel of line (pix_cnt==width_cfg-1)
- busy  out  1  state != IDLE
- frame_done  out  1  1-cycle pulse at end of captured frame
- frame_err  out  1  valid with frame_done: geometry error or overflow in that frame
- frame_cnt  out  16  completed captured frames, wraps
- ovf_cnt  out  16  pixels lost to fifo_full, saturates at 16'hFFFF

Behaviour:
- Stage 1 (input register): fv_q, lv_q, d_q sampled every pclk.
  - fv_q2 holds the previous fv_q; lv_q2 holds the previous lv_q.
  - fv_rise = fv_q & ~fv_q2; fv_fall = ~fv_q & fv_q2; lv_fall = ~lv_q & lv_q2.
- Stage 2 (output register): pix_* registered from stage 1. Pin-to-pix_data latency is 2 pclk.
- Reset: all outputs 0, counters 0, state IDLE, error flags cleared. Reset mid-frame drops the partial frame with no frame_done.
- FSM states:
  - IDLE: arm -> WAIT_SYNC.
  - WAIT_SYNC: fv_q==0 -> WAIT_SOF. Guarantees no partial frame is captured after arm or reset.
  - WAIT_SOF: on fv_rise, latch width_cfg/height_cfg into shadows.
    - skip_left==0 -> CAPTURE.
    - else decrement skip_left -> SKIP.
  - SKIP: fv_fall -> WAIT_SOF. No pixels or stats for the skipped frame.
  - CAPTURE: on fv_fall -> DONE.
  - DONE (1 cycle): frame_done=1, frame_err=err; frame_cnt++.
    - -> WAIT_SOF if cont_en & ~stop_pend (skip_left reloaded from skip_cfg).
    - else -> IDLE.
- skip_left: loaded from skip_cfg on arm and on each DONE. The first frame after arm is skipped skip_cfg times before capture.
- Capture rules: in CAPTURE, a pixel is present when fv_q & lv_q. pix_cnt increments per pixel; line_cnt increments on lv_fall.
  - Forward the pixel (pix_valid=1) only if pix_cnt<width_sh & line_cnt<height_sh & ~fifo_full.
  - Extra pixels or lines are discarded and set err.
  - A pixel present while fifo_full is dropped, sets err, and increments ovf_cnt (saturating).
  - pix_sof=1 on the forwarded pixel with line_cnt==0 & pix_cnt==0. If that pixel is dropped, no SOF is sent for the frame.
  - pix_eol=1 on the forwarded pixel with pix_cnt==width_sh-1.
  - On lv_fall: pix_cnt!=width_sh sets err; pix_cnt clears.
  - On fv_fall: line_cnt!=height_sh sets err; line_cnt clears.
  - err clears on entry to CAPTURE.
- arm while busy: ignored.
- stop:
  - In WAIT_SYNC/WAIT_SOF/SKIP -> IDLE next cycle.
  - In CAPTURE: sets stop_pend; the current frame completes, then -> IDLE.
  - arm and stop in the same cycle: stop wins (arm ignored).
- Config inputs are read only at arm/DONE (skip) and fv_rise (geometry). Mid-frame changes have no effect on the current frame.
- frame_cnt wraps FFFF->0. ovf_cnt cleared only by reset.

Optional Feature:
- Macro CAM_CAPTURE_TEST_PATTERN_EN.
- Defined: pix_data = zero-extended {line_cnt[7:0], pix_cnt[7:0]} of the forwarded pixel; D_IN is ignored. All timing, strobes and errors are unchanged.
- Undefined: pix_data = D_IN delayed 2 cycles.

Test Plan:
- width_cfg=4, height_cfg=3, cont_en=0, skip_cfg=0; arm with FV low, then a 4x3 frame -> 12 pix_valid; pix_sof on pixel 0; pix_eol on pixels 3/7/11; 1 frame_done with frame_err=0; frame_cnt=1; busy=0 afterwards.
- arm while FV=1 mid-frame -> no pixels from that frame; next full frame captured.
- cont_en=1, skip_cfg=2, 6 frames -> frames 3 and 6 captured; frame_cnt=2.
- fifo_full=1 for 2 pixel cycles in line 1 -> 10 pixels forwarded; ovf_cnt=2; frame_err=1.
- Line of 5 pixels with width_cfg=4 -> 5th pixel discarded, frame_err=1. A frame of 2 lines with height_cfg=3 also gives frame_err=1.
- stop mid-CAPTURE in continuous mode -> frame completes with frame_done, then IDLE. reset mid-frame -> outputs 0, no frame_done.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl: frame-capture sequencer between parallel sensor pins
// (FV/LV/D_IN on pclk) and the stream packer. Syncs to a clean frame
// boundary, applies frame decimation, checks geometry, emits pixel strobes
// with SOF/EOL markers, and keeps frame/overflow statistics.
// Optional build macro: CAM_CAPTURE_TEST_PATTERN_EN replaces pixel data
// with {line_cnt[7:0], pix_cnt[7:0]} of the forwarded pixel.
module cam_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 12,
  parameter int SKIP_W = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              FV,
  input  logic              LV,
  input  logic [DATA_W-1:0] D_IN,
  input  logic              arm,
  input  logic              stop,
  input  logic              cont_en,
  input  logic [SKIP_W-1:0] skip_cfg,
  input  logic [CNT_W-1:0]  width_cfg,
  input  logic [CNT_W-1:0]  height_cfg,
  input  logic              fifo_full,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_err,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       ovf_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SYNC, S_WAIT_SOF, S_SKIP, S_CAPTURE, S_DONE
  } state_t;

  state_t state, state_d;

  logic fv_q, fv_q2, lv_q, lv_q2;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
  logic [DATA_W-1:0] d_q;
`endif
  logic [SKIP_W-1:0] skip_left;
  logic [CNT_W-1:0]  width_sh, height_sh;
  logic [CNT_W-1:0]  pix_cnt, line_cnt, line_nx;
  logic              err, stop_pend;
  logic              fv_rise, fv_fall, lv_fall;
  logic              px_present, fwd, sof_hit, eol_hit, enter_cap;

  // Stage 1: register the sensor pins and keep one cycle of history for edges.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge pclk) begin
    if (reset) begin
      fv_q  <= 1'b0;
      fv_q2 <= 1'b0;
      lv_q  <= 1'b0;
      lv_q2 <= 1'b0;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
      d_q   <= '0;
`endif
    end else begin
      fv_q  <= FV;
      fv_q2 <= fv_q;
      lv_q  <= LV;
      lv_q2 <= lv_q;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
      d_q   <= D_IN;
`endif
    end
  end

  assign fv_rise    = fv_q & ~fv_q2;
  assign fv_fall    = ~fv_q & fv_q2;
  assign lv_fall    = ~lv_q & lv_q2;
  assign px_present = (state == S_CAPTURE) & fv_q & lv_q;
  assign fwd        = px_present & (pix_cnt < width_sh) & (line_cnt < height_sh) & ~fifo_full;
  assign sof_hit    = fwd & (pix_cnt == '0) & (line_cnt == '0);
  assign eol_hit    = fwd & (pix_cnt == width_sh - CNT_W'(1));
  assign enter_cap  = (state == S_WAIT_SOF) & (state_d == S_CAPTURE);
  // Line count including a line that ends in this very cycle, so a frame
  // whose last LV and FV fall together is still measured correctly.
  assign line_nx    = (lv_fall && line_cnt != '1) ? line_cnt + CNT_W'(1) : line_cnt;

  // FSM state register.
  always_ff @(posedge pclk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_d;
  end

  // FSM next-state logic; stop outranks arm and any frame-boundary event.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE:      if (arm && !stop) state_d = S_WAIT_SYNC;
      S_WAIT_SYNC: if (stop) state_d = S_IDLE;
                   else if (!fv_q) state_d = S_WAIT_SOF;
      S_WAIT_SOF:  if (stop) state_d = S_IDLE;
                   else if (fv_rise) state_d = (skip_left == '0) ? S_CAPTURE : S_SKIP;
      S_SKIP:      if (stop) state_d = S_IDLE;
                   else if (fv_fall) state_d = S_WAIT_SOF;
      S_CAPTURE:   if (fv_fall) state_d = S_DONE;
      S_DONE:      state_d = (cont_en && !stop_pend && !stop) ? S_WAIT_SOF : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy       = (state != S_IDLE);
    frame_done = (state == S_DONE);
    frame_err  = (state == S_DONE) & err;
  end

  // Decimation, geometry shadows, frame counters, error and statistics.
  always_ff @(posedge pclk) begin
    if (reset) begin
      skip_left <= '0;
      width_sh  <= '0;
      height_sh <= '0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      err       <= 1'b0;
      stop_pend <= 1'b0;
      frame_cnt <= '0;
      ovf_cnt   <= '0;
    end else begin
      if ((state == S_IDLE && state_d == S_WAIT_SYNC) || state == S_DONE)
        skip_left <= skip_cfg;
      else if (state == S_WAIT_SOF && state_d == S_SKIP)
        skip_left <= skip_left - SKIP_W'(1);

      if (state == S_WAIT_SOF && fv_rise) begin
        width_sh  <= width_cfg;
        height_sh <= height_cfg;
      end

      if (enter_cap) begin
        pix_cnt  <= '0;
        line_cnt <= '0;
        err      <= 1'b0;
      end else if (state == S_CAPTURE) begin
        if (lv_fall)                          pix_cnt <= '0;
        else if (px_present && pix_cnt != '1) pix_cnt <= pix_cnt + CNT_W'(1);
        line_cnt <= fv_fall ? '0 : line_nx;
        // Dropped pixels (extra geometry or overflow) and wrong line/frame sizes.
        if ((px_present && !fwd) ||
            (lv_fall && pix_cnt != width_sh) ||
            (fv_fall && line_nx != height_sh))
          err <= 1'b1;
      end

      if (state == S_CAPTURE && stop) stop_pend <= 1'b1;
      else if (state == S_DONE)       stop_pend <= 1'b0;

      if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;

      if (px_present && fifo_full && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end

  // Stage 2: registered pixel strobes toward the packer.
  always_ff @(posedge pclk) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      pix_data  <= '0;
    end else begin
      pix_valid <= fwd;
      pix_sof   <= sof_hit;
      pix_eol   <= eol_hit;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
      if (fwd) pix_data <= DATA_W'({line_cnt[7:0], pix_cnt[7:0]});
`else
      pix_data  <= d_q;
`endif
    end
  end

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Self-checking bench for cam_capture_ctrl: randomized frames checked against
// a frame-level reference model (expected pixel and frame-done queues).
module tb_cam_capture_ctrl;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 12;
  localparam int SKIP_W = 4;

  logic              pclk = 1'b0;
  logic              reset, FV, LV, arm, stop, cont_en, fifo_full;
  logic [DATA_W-1:0] D_IN;
  logic [SKIP_W-1:0] skip_cfg;
  logic [CNT_W-1:0]  width_cfg, height_cfg;
  logic              pix_valid, pix_sof, pix_eol, busy, frame_done, frame_err;
  logic [DATA_W-1:0] pix_data;
  logic [15:0]       frame_cnt, ovf_cnt;

  cam_capture_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SKIP_W(SKIP_W)) dut (
    .pclk(pclk), .reset(reset), .FV(FV), .LV(LV), .D_IN(D_IN),
    .arm(arm), .stop(stop), .cont_en(cont_en), .skip_cfg(skip_cfg),
    .width_cfg(width_cfg), .height_cfg(height_cfg), .fifo_full(fifo_full),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .busy(busy), .frame_done(frame_done),
    .frame_err(frame_err), .frame_cnt(frame_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              sof;
    logic              eol;
  } px_t;

  px_t  exp_px[$];
  bit   exp_done[$];
  px_t  e_px;
  bit   e_err;
  int   n_checks = 0, n_errors = 0;
  int   exp_frame_cnt = 0, exp_ovf = 0;
  int   done_seen = 0, pv_seen = 0;
  bit   mon_en = 1'b0;
  bit   arm_req = 1'b0, stop_req = 1'b0, ff_pend = 1'b0;
  int   line_len[8];
  bit   full_map[8][16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Output monitor / scoreboard, sampled on the falling edge.
  always @(negedge pclk) begin
    if (frame_done) done_seen++;
    if (pix_valid) pv_seen++;
    if (mon_en) begin
      if (pix_valid) begin
        check("pix_expected", 32'(exp_px.size() != 0), 1);
        if (exp_px.size() != 0) begin
          e_px = exp_px.pop_front();
          check("pix_data", 32'(pix_data), 32'(e_px.data));
          check("pix_sof", 32'(pix_sof), 32'(e_px.sof));
          check("pix_eol", 32'(pix_eol), 32'(e_px.eol));
        end
      end else if (pix_sof || pix_eol) begin
        check("marker_without_valid", {30'd0, pix_sof, pix_eol}, 0);
      end
      if (frame_done) begin
        check("done_expected", 32'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          e_err = exp_done.pop_front();
          check("frame_err", 32'(frame_err), 32'(e_err));
        end
      end
    end
  end

  // One pclk step of pin stimulus. fifo_full lags the pins by one cycle so a
  // pixel's full flag lines up with that pixel inside the registered input.
  task automatic drive(input bit fv, input bit lv, input bit pix_full);
    @(negedge pclk);
    FV = fv; LV = lv; D_IN = DATA_W'($urandom);
    arm = arm_req; stop = stop_req; arm_req = 0; stop_req = 0;
    fifo_full = ff_pend;
    ff_pend = (fv && lv) ? pix_full : ($urandom_range(0, 3) == 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0);
  endtask

  task automatic set_lines(input int nl, input int len);
    for (int l = 0; l < 8; l++) begin
      line_len[l] = (l < nl) ? len : 0;
      for (int p = 0; p < 16; p++) full_map[l][p] = 0;
    end
  endtask

  // Drive one frame of nl lines (lengths from line_len, overflow from
  // full_map) with geometry w x h. When cap is set the model derives the
  // expected forwarded pixels, frame error and statistics.
  task automatic run_frame(input int nl, input int w, input int h, input bit cap,
                           input int arm_line, input int stop_line);
    bit err;
    logic [DATA_W-1:0] ed;
    err = (nl != h);
    width_cfg = CNT_W'(w); height_cfg = CNT_W'(h);
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int l = 0; l < nl; l++) begin
      if (l == arm_line) arm_req = 1;
      if (l == stop_line) stop_req = 1;
      if (line_len[l] != w) err = 1;
      for (int p = 0; p < line_len[l]; p++) begin
        drive(1, 1, full_map[l][p]);
        if (l == 0 && p == 0) begin
          width_cfg = CNT_W'($urandom); height_cfg = CNT_W'($urandom);
        end
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        ed = DATA_W'({l[7:0], p[7:0]});
`else
        ed = D_IN;
`endif
        if (cap) begin
          if (full_map[l][p]) begin
            err = 1;
            if (exp_ovf < 65535) exp_ovf++;
          end
          if (p < w && l < h && !full_map[l][p])
            exp_px.push_back('{data: ed, sof: (l == 0 && p == 0), eol: (p == w - 1)});
        end
      end
      drive(1, 0, 0);
      drive(1, 0, 0);
    end
    drive(0, 0, 0);
    if (cap) begin
      exp_done.push_back(err);
      exp_frame_cnt = (exp_frame_cnt + 1) % 65536;
    end
    idle(5);
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_frame_cnt));
    check({tag, "_ovf_cnt"}, 32'(ovf_cnt), 32'(exp_ovf));
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_pix_left"}, 32'(exp_px.size()), 0);
    check({tag, "_done_left"}, 32'(exp_done.size()), 0);
  endtask

  task automatic do_arm();
    arm_req = 1;
    idle(3);
  endtask

  initial begin
    int pv0, done0, sk, w, h, nl;
    reset = 1; FV = 0; LV = 0; D_IN = '0; arm = 0; stop = 0; cont_en = 0;
    fifo_full = 0; skip_cfg = '0; width_cfg = 12'd4; height_cfg = 12'd3;
    idle(3);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_ovf_cnt", 32'(ovf_cnt), 0);
    reset = 0;
    mon_en = 1;
    idle(2);

    // Basic 4x3 single frame.
    pv0 = pv_seen;
    set_lines(3, 4);
    do_arm();
    check("armed_busy", 32'(busy), 1);
    run_frame(3, 4, 3, 1, -1, -1);
    check("basic_pix_count", 32'(pv_seen - pv0), 12);
    check_stats("basic");

    // Arm mid-frame: that frame is ignored, next one captured.
    run_frame(3, 4, 3, 0, 1, -1);
    run_frame(3, 4, 3, 1, -1, -1);
    check_stats("arm_mid");

    // Continuous with skip_cfg=2 over 6 frames: frames 3 and 6 captured.
    cont_en = 1; skip_cfg = 4'd2;
    do_arm();
    for (int i = 0; i < 6; i++) run_frame(3, 4, 3, (i % 3 == 2), -1, -1);
    stop_req = 1;
    idle(3);
    check_stats("skip");
    cont_en = 0; skip_cfg = '0;

    // FIFO full on two pixels of line 1.
    pv0 = pv_seen;
    set_lines(3, 4);
    full_map[1][1] = 1; full_map[1][2] = 1;
    do_arm();
    run_frame(3, 4, 3, 1, -1, -1);
    check("ovf_pix_count", 32'(pv_seen - pv0), 10);
    check_stats("ovf");

    // Long line (5 pixels at width 4), then a short frame (2 of 3 lines).
    set_lines(3, 4);
    line_len[1] = 5;
    do_arm();
    run_frame(3, 4, 3, 1, -1, -1);
    set_lines(2, 4);
    do_arm();
    run_frame(2, 4, 3, 1, -1, -1);
    check_stats("geom");

    // Stop mid-capture in continuous mode: frame completes, then idle.
    cont_en = 1;
    set_lines(3, 4);
    do_arm();
    run_frame(3, 4, 3, 1, -1, 1);
    run_frame(3, 4, 3, 0, -1, -1);
    check_stats("stop");

    // Arm and stop together: stop wins.
    arm_req = 1; stop_req = 1;
    idle(2);
    check("arm_stop_busy", 32'(busy), 0);
    cont_en = 0;

    // Randomized single-shot captures with decimation and geometry faults.
    for (int it = 0; it < 12; it++) begin
      sk = $urandom_range(0, 2);
      skip_cfg = SKIP_W'(sk);
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      do_arm();
      for (int j = 0; j <= sk; j++) begin
        nl = h;
        if ($urandom_range(0, 3) == 0) nl = ($urandom_range(0, 1) == 1) ? h + 1 : ((h > 1) ? h - 1 : h);
        set_lines(nl, w);
        for (int l = 0; l < nl; l++) begin
          if ($urandom_range(0, 3) == 0) line_len[l] = ($urandom_range(0, 1) == 1) ? w + 1 : ((w > 1) ? w - 1 : w);
          for (int p = 0; p < line_len[l]; p++) full_map[l][p] = ($urandom_range(0, 7) == 0);
        end
        run_frame(nl, w, h, (j == sk), -1, -1);
      end
      check_stats("rand");
    end
    skip_cfg = '0;

    // Reset mid-frame: outputs clear, no frame_done, statistics cleared.
    cont_en = 1;
    do_arm();
    mon_en = 0;
    done0 = done_seen;
    drive(1, 0, 0);
    drive(1, 0, 0);
    for (int p = 0; p < 3; p++) drive(1, 1, 0);
    reset = 1;
    drive(1, 1, 0);
    drive(1, 1, 0);
    check("midrst_pix_valid", 32'(pix_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_frame_cnt", 32'(frame_cnt), 0);
    check("midrst_ovf_cnt", 32'(ovf_cnt), 0);
    reset = 0;
    exp_frame_cnt = 0; exp_ovf = 0;
    mon_en = 1;
    drive(1, 0, 0);
    drive(0, 0, 0);
    idle(5);
    check("midrst_no_done", 32'(done_seen - done0), 0);
    check_stats("midrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
